mem_wb: RTL and testbench
=========================

Name: mem_wb

Overview:
- Pipeline register between the MEM stage and the regfile write port (we/waddr/wdata) of the 5-stage MIPS core.
- Registers MEM results and applies the pipeline-controller stall and flush rules, including bubble insertion.
- Suppresses writes to $0.
- Keeps saturating retire and stall performance counters for the debug/test harness.

Parameters:
DATA_W, 32, register data width (matches RegBus)
ADDR_W, 5, register address width (matches RegAddrBus)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
mem_valid  in  1  MEM slot holds a real instruction (0 = bubble)
mem_wd  in  ADDR_W  destination register from MEM
mem_wreg  in  1  write-enable from MEM
mem_wdata  in  DATA_W  result from MEM
stall  in  6  controller stall vector; bit4 = MEM stalled, bit5 = WB stalled
flush  in  1  exception/redirect flush
wb_valid  out  1  WB slot holds a real instruction
wb_wd  out  ADDR_W  to regfile waddr
wb_wreg  out  1  to regfile we
wb_wdata  out  DATA_W  to regfile wdata
retire_cnt  out  CNT_W  instructions retired through WB
stall_cnt  out  CNT_W  cycles with MEM stalled

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. At a rising edge with rst=1, all outputs go to 0: wb_valid, wb_wd, wb_wreg, wb_wdata, retire_cnt, stall_cnt. Reset overrides every other input, including mid-stall.
- Latency: 1 cycle, MEM inputs to wb_* outputs. Regfile internal bypass covers same-cycle read-after-write. This block does no forwarding.
- Update priority at each posedge, highest first:
  1. rst: reset as above.
  2. flush=1: load a bubble.
  3. stall[4]=1 and stall[5]=0: load a bubble (MEM held, WB drains).
  4. stall[4]=1 and stall[5]=1: hold all wb_* outputs unchanged.
  5. stall[4]=0: advance. Load wb_valid=mem_valid, wb_wd=mem_wd, wb_wdata=mem_wdata, and wb_wreg = mem_wreg & mem_valid & (mem_wd != 0).
- Bubble: wb_valid=0, wb_wreg=0, wb_wd=0, wb_wdata=0.
- stall[4]=0 with stall[5]=1 is illegal from the controller. Treat it as advance.
- retire_cnt: +1 on every cycle that takes path 5 with mem_valid=1, whether or not the instruction writes a register. Hold and bubble cycles do not count. Saturates at all-ones, no wrap.
- stall_cnt: +1 on every non-reset cycle with stall[4]=1, including flush cycles. Saturates at all-ones.
- $0 rule: wb_wreg is never 1 with wb_wd=0.
- No FSM beyond the priority mux. Three logical states per cycle: ADVANCE, BUBBLE, HOLD.
- ADVANCE → HOLD → BUBBLE sequences must preserve the held instruction, so the regfile write is presented for every cycle it is held.

Decomposition:
- Shared package/defines: stall-bit indices (STALL_MEM=4, STALL_WB=5), WriteEnable/WriteDisable, RstEnable, ZeroWord, NOPRegAddr.
- One natural sub-module, sat_counter (parameter CNT_W; inputs clk, rst, inc; output count). It is instantiated twice.

Test Plan:
- Reset mid-hold: load mem_wd=3, mem_wdata=0x1234, mem_wreg=1, mem_valid=1, then stall=6'b110000, then rst=1 for one edge → all outputs 0 next cycle; counters 0.
- Advance: mem_valid=1, mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF, stall=0 → next cycle wb_wreg=1, wb_wd=5, wb_wdata=0xDEADBEEF, wb_valid=1; retire_cnt=1.
- $0 suppression: mem_wd=0, mem_wreg=1, mem_wdata=0xFFFFFFFF → wb_wreg=0, wb_valid=1; retire_cnt increments.
- Hold then bubble: advance wd=7, data=0x55; then stall=6'b110000 for 2 cycles → outputs unchanged both cycles. Then stall=6'b010000 → bubble (wb_wreg=0). stall_cnt=3, retire_cnt unchanged.
- Flush beats advance: flush=1 with stall=0 and valid write to r9 → bubble; retire_cnt unchanged.
- Saturation: with CNT_W=4, 20 consecutive valid advances → retire_cnt stays at 15 from the 15th onward.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared constants and the per-cycle update classification for the MEM/WB pipeline register.
package mem_wb_pkg;

    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        RstEnable    = 1'b1;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    typedef enum logic [1:0] {
        WB_ADVANCE = 2'd0,
        WB_BUBBLE  = 2'd1,
        WB_HOLD    = 2'd2
    } wb_op_e;

    // Flush outranks stalls; MEM-advancing with WB stalled is illegal and treated as advance.
    function automatic wb_op_e classify_op(input logic [5:0] stall, input logic flush);
        wb_op_e op;
        if (flush)
            op = WB_BUBBLE;
        else if (stall[STALL_MEM] && !stall[STALL_WB])
            op = WB_BUBBLE;
        else if (stall[STALL_MEM] && stall[STALL_WB])
            op = WB_HOLD;
        else
            op = WB_ADVANCE;
        return op;
    endfunction

endpackage

// File: rtl/mem_wb_sat_counter.sv
// Saturating up-counter: count advances by one per cycle with inc high, sticking at all-ones.
// Latency 1 cycle from inc to count; no backpressure, synchronous active-high reset.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    import mem_wb_pkg::*;

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (rst == RstEnable)
            r_count <= '0;
        else if (inc && !w_at_max)
            r_count <= r_count + 1'b1;
    end

endmodule

// File: rtl/mem_wb.sv
// MEM->WB pipeline register with stall/flush/bubble rules, $0 write suppression and perf counters.
// Latency 1 cycle; holds when MEM and WB are both stalled, bubbles when only MEM is stalled or on flush.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [5:0]        stall,
    input  logic              flush,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_wd;
    logic              r_wreg;
    logic [DATA_W-1:0] r_wdata;

    wb_op_e w_op;
    logic   w_wreg_next;
    logic   w_retire;
    logic   w_mem_stalled;

    assign w_op          = classify_op(stall, flush);
    assign w_mem_stalled = stall[STALL_MEM];

    // Writes to $0 never reach the regfile, so wb_wreg can never pair with address 0.
    assign w_wreg_next = mem_wreg & mem_valid & (mem_wd != ADDR_W'(NOPRegAddr));
    assign w_retire    = (w_op == WB_ADVANCE) & mem_valid;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_valid <= 1'b0;
            r_wd    <= ADDR_W'(NOPRegAddr);
            r_wreg  <= WriteDisable;
            r_wdata <= DATA_W'(ZeroWord);
        end else begin
            case (w_op)
                WB_ADVANCE: begin
                    r_valid <= mem_valid;
                    r_wd    <= mem_wd;
                    r_wreg  <= w_wreg_next ? WriteEnable : WriteDisable;
                    r_wdata <= mem_wdata;
                end
                WB_BUBBLE: begin
                    r_valid <= 1'b0;
                    r_wd    <= ADDR_W'(NOPRegAddr);
                    r_wreg  <= WriteDisable;
                    r_wdata <= DATA_W'(ZeroWord);
                end
                default: begin
                    r_valid <= r_valid;
                    r_wd    <= r_wd;
                    r_wreg  <= r_wreg;
                    r_wdata <= r_wdata;
                end
            endcase
        end
    end

    assign wb_valid = r_valid;
    assign wb_wd    = r_wd;
    assign wb_wreg  = r_wreg;
    assign wb_wdata = r_wdata;

    sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_retire),
        .count (retire_cnt)
    );

    // Flush cycles still count as stalled when MEM is held.
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_mem_stalled),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [5:0]  stall;
    logic        flush;

    logic        wb_valid,  s_wb_valid;
    logic [4:0]  wb_wd,     s_wb_wd;
    logic        wb_wreg,   s_wb_wreg;
    logic [31:0] wb_wdata,  s_wb_wdata;
    logic [31:0] retire_cnt, stall_cnt;
    logic [3:0]  s_retire_cnt, s_stall_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic        e_valid;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    longint      e_retire;
    longint      e_stall;

    always #5 clk = ~clk;

    mem_wb dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata), .stall(stall), .flush(flush),
        .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    mem_wb #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata), .stall(stall), .flush(flush),
        .wb_valid(s_wb_valid), .wb_wd(s_wb_wd), .wb_wreg(s_wb_wreg), .wb_wdata(s_wb_wdata),
        .retire_cnt(s_retire_cnt), .stall_cnt(s_stall_cnt)
    );

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic logic [38:0] exp_wb();
        return {e_valid, e_wd, e_wreg, e_wdata};
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, then settle for sampling.
    task automatic step(input logic r, input logic v, input logic [4:0] wd, input logic we,
                        input logic [31:0] d, input logic [5:0] st, input logic fl);
        rst = r; mem_valid = v; mem_wd = wd; mem_wreg = we; mem_wdata = d; stall = st; flush = fl;
        @(posedge clk);
        if (r) begin
            {e_valid, e_wd, e_wreg, e_wdata} = '0;
            e_retire = 0;
            e_stall  = 0;
        end else begin
            if (st[4]) e_stall++;
            if (fl || (st[4] && !st[5])) begin
                {e_valid, e_wd, e_wreg, e_wdata} = '0;
            end else if (!(st[4] && st[5])) begin
                e_valid = v;
                e_wd    = wd;
                e_wdata = d;
                e_wreg  = v && we && (wd != 5'd0);
                if (v) e_retire++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 5'd9, 1, 32'hAAAA_5555, 6'b0, 0);
        checks++;
        if ({wb_valid, wb_wd, wb_wreg, wb_wdata, retire_cnt, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset: wb=%h ret=%0d stl=%0d expected all zero",
                     {wb_valid, wb_wd, wb_wreg, wb_wdata}, retire_cnt, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_hold();
        step(0, 1, 5'd3, 1, 32'h1234, 6'b0, 0);
        step(0, 1, 5'd4, 1, 32'h9999, 6'b110000, 0);
        checks++;
        if ({wb_valid, wb_wd, wb_wreg, wb_wdata} !== {1'b1, 5'd3, 1'b1, 32'h1234}) begin
            errors++;
            $display("FAIL mid_hold_pre: wb=%h expected %h", {wb_valid, wb_wd, wb_wreg, wb_wdata},
                     {1'b1, 5'd3, 1'b1, 32'h1234});
        end
        step(1, 1, 5'd4, 1, 32'h9999, 6'b110000, 0);
        checks++;
        if ({wb_valid, wb_wd, wb_wreg, wb_wdata, retire_cnt, stall_cnt,
             s_retire_cnt, s_stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid_hold: wb=%h ret=%0d stl=%0d expected all zero",
                     {wb_valid, wb_wd, wb_wreg, wb_wdata}, retire_cnt, stall_cnt);
        end
    endtask

    task automatic test_advance();
        step(0, 1, 5'd5, 1, 32'hDEAD_BEEF, 6'b0, 0);
        checks++;
        if ({wb_valid, wb_wd, wb_wreg, wb_wdata, retire_cnt} !==
            {1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'd1}) begin
            errors++;
            $display("FAIL advance: wb=%h ret=%0d expected wb=%h ret=1",
                     {wb_valid, wb_wd, wb_wreg, wb_wdata}, retire_cnt,
                     {1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF});
        end
    endtask

    task automatic test_zero_reg();
        step(0, 1, 5'd0, 1, 32'hFFFF_FFFF, 6'b0, 0);
        checks++;
        if ({wb_valid, wb_wreg, wb_wd, retire_cnt} !== {1'b1, 1'b0, 5'd0, 32'd2}) begin
            errors++;
            $display("FAIL zero_reg: valid=%b wreg=%b wd=%0d ret=%0d expected 1 0 0 2",
                     wb_valid, wb_wreg, wb_wd, retire_cnt);
        end
    endtask

    task automatic test_hold_bubble();
        longint ret0;
        step(1, 0, 5'd0, 0, 32'h0, 6'b0, 0);
        step(0, 1, 5'd7, 1, 32'h55, 6'b0, 0);
        ret0 = e_retire;
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 5'd12, 1, 32'hBAD0 + i, 6'b110000, 0);
            checks++;
            if ({wb_valid, wb_wd, wb_wreg, wb_wdata} !== {1'b1, 5'd7, 1'b1, 32'h55}) begin
                errors++;
                $display("FAIL hold_%0d: wb=%h expected %h", i, {wb_valid, wb_wd, wb_wreg, wb_wdata},
                         {1'b1, 5'd7, 1'b1, 32'h55});
            end
        end
        step(0, 1, 5'd12, 1, 32'hBAD2, 6'b010000, 0);
        checks++;
        if ({wb_valid, wb_wd, wb_wreg, wb_wdata} !== '0 || stall_cnt !== 32'd3 ||
            retire_cnt !== 32'(ret0)) begin
            errors++;
            $display("FAIL bubble: wb=%h stl=%0d ret=%0d expected wb=0 stl=3 ret=%0d",
                     {wb_valid, wb_wd, wb_wreg, wb_wdata}, stall_cnt, retire_cnt, ret0);
        end
    endtask

    task automatic test_flush();
        logic [31:0] ret0;
        step(0, 1, 5'd2, 1, 32'h77, 6'b0, 0);
        ret0 = retire_cnt;
        step(0, 1, 5'd9, 1, 32'hCAFE, 6'b0, 1);
        checks++;
        if ({wb_valid, wb_wd, wb_wreg, wb_wdata} !== '0 || retire_cnt !== ret0) begin
            errors++;
            $display("FAIL flush: wb=%h ret=%0d expected wb=0 ret=%0d",
                     {wb_valid, wb_wd, wb_wreg, wb_wdata}, retire_cnt, ret0);
        end
        // flush during a MEM stall still counts as a stall cycle
        step(0, 1, 5'd9, 1, 32'hCAFE, 6'b110000, 1);
        checks++;
        if (wb_valid !== 1'b0 || stall_cnt !== 32'(e_stall)) begin
            errors++;
            $display("FAIL flush_stall: valid=%b stl=%0d expected 0 %0d", wb_valid, stall_cnt, e_stall);
        end
    endtask

    task automatic test_saturation();
        step(1, 0, 5'd0, 0, 32'h0, 6'b0, 0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, 5'(i), 1, 32'(i), 6'b0, 0);
            checks++;
            if (s_retire_cnt !== 4'(sat(longint'(i), 15)) || retire_cnt !== 32'(i)) begin
                errors++;
                $display("FAIL sat_retire_%0d: narrow=%0d wide=%0d expected %0d %0d",
                         i, s_retire_cnt, retire_cnt, sat(longint'(i), 15), i);
            end
        end
        for (int i = 1; i <= 18; i++) step(0, 0, 5'd0, 0, 32'h0, 6'b110000, 0);
        checks++;
        if (s_stall_cnt !== 4'd15 || stall_cnt !== 32'd18) begin
            errors++;
            $display("FAIL sat_stall: narrow=%0d wide=%0d expected 15 18", s_stall_cnt, stall_cnt);
        end
    endtask

    task automatic test_random();
        logic [5:0] st;
        int sel;
        step(1, 0, 5'd0, 0, 32'h0, 6'b0, 0);
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    st = 6'b110000;
                2:       st = 6'b010000;
                3:       st = 6'b100000;
                4:       st = 6'($urandom);
                default: st = 6'b0;
            endcase
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                 1'($urandom), $urandom, st, $urandom_range(0, 15) == 0);
            checks++;
            if ({wb_valid, wb_wd, wb_wreg, wb_wdata} !== exp_wb() ||
                retire_cnt !== 32'(e_retire) || stall_cnt !== 32'(e_stall) ||
                s_retire_cnt !== 4'(sat(e_retire, 15)) || s_stall_cnt !== 4'(sat(e_stall, 15)) ||
                (wb_wreg && wb_wd == 5'd0)) begin
                errors++;
                $display("FAIL random_%0d: wb=%h ret=%0d stl=%0d sret=%0d sstl=%0d expected wb=%h ret=%0d stl=%0d",
                         i, {wb_valid, wb_wd, wb_wreg, wb_wdata}, retire_cnt, stall_cnt,
                         s_retire_cnt, s_stall_cnt, exp_wb(), e_retire, e_stall);
            end
        end
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; mem_wd = '0; mem_wreg = 1'b0;
        mem_wdata = '0; stall = '0; flush = 1'b0;
        @(negedge clk);
        test_reset();
        test_reset_mid_hold();
        test_advance();
        test_zero_reg();
        test_hold_bubble();
        test_flush();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
